// File: rtl/sdram_wr_burst_ctrl.sv
// Drains the camera pixel write FIFO into SDRAM as fixed-length bursts. Writes go into a
// ping-pong pair of frame buffers, and the bank holding the last complete frame is published to the read side.
module sdram_wr_burst_ctrl #(
    parameter int                BURST_LEN   = 256,
    parameter int                FRAME_WORDS = 307200,
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] BANK0_BASE  = ADDR_W'(24'h000000),
    parameter logic [ADDR_W-1:0] BANK1_BASE  = ADDR_W'(24'h080000)
) (
    input  logic              S_CLK,
    input  logic              RST,
    input  logic              frame_start,
    input  logic [10:0]       fifo_rd_usedw,
    output logic              fifo_rd_req,
    input  logic [15:0]       fifo_rd_data,
    output logic              sdram_wr_req,
    input  logic              sdram_wr_ack,
    output logic [ADDR_W-1:0] sdram_wr_addr,
    input  logic              sdram_wr_data_req,
    output logic [15:0]       sdram_wr_data,
    input  logic              sdram_wr_done,
    output logic              wr_bank,
    output logic              rd_bank,
    output logic              rd_valid,
    output logic              frame_done,
    output logic              frame_drop,
    output logic              err_sticky
);

    localparam int                NBURST     = FRAME_WORDS / BURST_LEN;
    localparam int                IDX_W      = $clog2(NBURST + 1);
    localparam int                CNT_W      = $clog2(BURST_LEN + 1);
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NBURST - 1);
    localparam logic [CNT_W-1:0]  LAST_WORD  = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] BURST_STEP = ADDR_W'(BURST_LEN);
    localparam logic [11:0]       BURST_THR  = 12'(BURST_LEN);

    typedef enum logic [2:0] {
        S_SYNC,
        S_IDLE,
        S_REQ,
        S_DATA,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] burst_idx;
    logic [CNT_W-1:0] word_cnt;
    logic             start_pend;
    logic             restart, launch, burst_end, frame_end;
    logic             usedw_ok;

    assign usedw_ok      = ({1'b0, fifo_rd_usedw} >= BURST_THR);
    assign sdram_wr_req  = (state == S_REQ);
    // Controller asks one cycle ahead, so the FIFO strobe maps straight through.
    assign fifo_rd_req   = sdram_wr_data_req && (state == S_DATA);
    assign sdram_wr_data = fifo_rd_data;

    always_comb begin
        state_n   = state;
        restart   = 1'b0;
        launch    = 1'b0;
        burst_end = 1'b0;
        frame_end = 1'b0;
        case (state)
            S_SYNC: if (start_pend || frame_start) state_n = S_IDLE;
            S_IDLE: begin
                if (start_pend || frame_start) begin
                    restart = 1'b1;
                end else if (usedw_ok) begin
                    launch  = 1'b1;
                    state_n = S_REQ;
                end
            end
            S_REQ:  if (sdram_wr_ack) state_n = S_DATA;
            S_DATA: if (sdram_wr_data_req && word_cnt == LAST_WORD) state_n = S_DONE;
            S_DONE: begin
                if (sdram_wr_done) begin
                    burst_end = 1'b1;
                    if (burst_idx == LAST_IDX) begin
                        frame_end = 1'b1;
                        state_n   = S_SYNC;
                    end else begin
                        state_n   = S_IDLE;
                    end
                end
            end
            default: state_n = S_SYNC;
        endcase
    end

    always_ff @(posedge S_CLK) begin
        if (RST) begin
            state         <= S_SYNC;
            burst_idx     <= '0;
            word_cnt      <= '0;
            start_pend    <= 1'b0;
            sdram_wr_addr <= '0;
            wr_bank       <= 1'b0;
            rd_bank       <= 1'b0;
            rd_valid      <= 1'b0;
            frame_done    <= 1'b0;
            frame_drop    <= 1'b0;
            err_sticky    <= 1'b0;
        end else begin
            state      <= state_n;
            frame_done <= frame_end;
            frame_drop <= restart && (burst_idx != '0);

            // A start seen mid-burst is held; SYNC and IDLE always consume it the cycle they see it.
            if (state == S_REQ || state == S_DATA || state == S_DONE) begin
                if (frame_start) start_pend <= 1'b1;
            end else begin
                start_pend <= 1'b0;
            end

            if (restart || (state == S_SYNC && state_n == S_IDLE)) burst_idx <= '0;

            if (launch)
                sdram_wr_addr <= (wr_bank ? BANK1_BASE : BANK0_BASE)
                               + ADDR_W'(burst_idx) * BURST_STEP;

            if (state == S_REQ && sdram_wr_ack) word_cnt <= '0;
            else if (fifo_rd_req)                word_cnt <= word_cnt + 1'b1;

            if (burst_end) begin
                if (frame_end) begin
                    burst_idx <= '0;
                    rd_bank   <= wr_bank;
                    wr_bank   <= ~wr_bank;
                    rd_valid  <= 1'b1;
                end else begin
                    burst_idx <= burst_idx + 1'b1;
                end
            end

            if ((sdram_wr_data_req && state != S_DATA) || (sdram_wr_done && state != S_DONE))
                err_sticky <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Directed-plus-random bench for sdram_wr_burst_ctrl with a small frame so whole frames fit in a short run.
// The reference model tracks bank, burst index and frame events per burst transaction.
module tb_sdram_wr_burst_ctrl;

    localparam int          BL = 16;
    localparam int          FW = 96;
    localparam int          NB = FW / BL;
    localparam logic [23:0] B0 = 24'h000000;
    localparam logic [23:0] B1 = 24'hFFFFD0;   // bursts in bank 1 wrap past 2^24

    logic        clk = 1'b0;
    logic        rst;
    logic        frame_start;
    logic [10:0] usedw;
    logic        fifo_rd_req;
    logic [15:0] rdata;
    logic        wr_req;
    logic        wr_ack;
    logic [23:0] wr_addr;
    logic        dreq;
    logic [15:0] wr_data;
    logic        wr_done;
    logic        wr_bank, rd_bank, rd_valid, frame_done, frame_drop, err_sticky;

    sdram_wr_burst_ctrl #(
        .BURST_LEN(BL), .FRAME_WORDS(FW), .ADDR_W(24), .BANK0_BASE(B0), .BANK1_BASE(B1)
    ) dut (
        .S_CLK(clk), .RST(rst), .frame_start(frame_start), .fifo_rd_usedw(usedw),
        .fifo_rd_req(fifo_rd_req), .fifo_rd_data(rdata), .sdram_wr_req(wr_req),
        .sdram_wr_ack(wr_ack), .sdram_wr_addr(wr_addr), .sdram_wr_data_req(dreq),
        .sdram_wr_data(wr_data), .sdram_wr_done(wr_done), .wr_bank(wr_bank),
        .rd_bank(rd_bank), .rd_valid(rd_valid), .frame_done(frame_done),
        .frame_drop(frame_drop), .err_sticky(err_sticky)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int seen_done = 0;
    int seen_drop = 0;

    // reference model state
    bit m_wr_bank, m_rd_bank, m_rd_valid, m_sync, m_err;
    int m_idx, m_done, m_drop;

    always @(negedge clk) begin
        if (frame_done === 1'b1) seen_done++;
        if (frame_drop === 1'b1) seen_drop++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_wr_req"},   32'(wr_req), 0);
        chk({tag, "_rd_req"},   32'(fifo_rd_req), 0);
        chk({tag, "_addr"},     32'(wr_addr), 0);
        chk({tag, "_wr_bank"},  32'(wr_bank), 0);
        chk({tag, "_rd_bank"},  32'(rd_bank), 0);
        chk({tag, "_rd_valid"}, 32'(rd_valid), 0);
        chk({tag, "_fdone"},    32'(frame_done), 0);
        chk({tag, "_fdrop"},    32'(frame_drop), 0);
        chk({tag, "_err"},      32'(err_sticky), 0);
    endtask

    task automatic start_frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        m_sync = 1'b0;
    endtask

    task automatic sync_hold_check(input string tag);
        usedw = 11'(BL);
        repeat (5) begin
            tick();
            chk(tag, 32'(wr_req), 0);
        end
        usedw = '0;
    endtask

    task automatic wait_req(output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            tick();
            got = wr_req;
        end
        chk("req_seen", 32'(got), 1);
    endtask

    // One full burst transaction; fs_at = word index at which frame_start pulses (-1 none),
    // fs_done = frame_start together with wr_done, extra = one data_req too many.
    task automatic burst(input bit lat_chk, input int fs_at, input bit fs_done, input bit extra);
        logic [23:0] ea;
        bit got;
        bit pend;
        ea = 24'(int'(m_wr_bank ? B1 : B0) + m_idx * BL);
        if (lat_chk) begin
            usedw = 11'(BL - 1);
            repeat (6) begin
                tick();
                chk("no_req_below_thr", 32'(wr_req), 0);
            end
            usedw = 11'(BL);
            tick();
            chk("req_latency", 32'(wr_req), 1);
        end else begin
            usedw = 11'(BL + $urandom_range(0, 200));
            wait_req(got);
        end
        chk("wr_addr", 32'(wr_addr), 32'(ea));
        usedw = 11'($urandom_range(0, 2047));
        repeat ($urandom_range(0, 2)) begin
            tick();
            chk("req_hold", 32'(wr_req), 1);
            chk("addr_hold", 32'(wr_addr), 32'(ea));
        end
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        chk("req_after_ack", 32'(wr_req), 0);
        for (int k = 0; k < BL; k++) begin
            repeat ($urandom_range(0, 2)) begin
                tick();
                chk("rd_req_gap", 32'(fifo_rd_req), 0);
            end
            dreq  = 1'b1;
            rdata = 16'($urandom);
            if (fs_at == k) frame_start = 1'b1;
            #1;
            chk("rd_req_follow", 32'(fifo_rd_req), 1);
            chk("wr_data_pass", 32'(wr_data), 32'(rdata));
            tick();
            dreq = 1'b0;
            frame_start = 1'b0;
        end
        chk("addr_stable_done", 32'(wr_addr), 32'(ea));
        if (extra) begin
            dreq = 1'b1;
            #1;
            chk("rd_req_extra", 32'(fifo_rd_req), 0);
            tick();
            dreq = 1'b0;
            chk("err_set", 32'(err_sticky), 1);
            m_err = 1'b1;
        end
        repeat ($urandom_range(0, 3)) tick();
        wr_done = 1'b1;
        if (fs_done) frame_start = 1'b1;
        tick();
        wr_done = 1'b0;
        frame_start = 1'b0;
        usedw = '0;

        pend = (fs_at >= 0) || fs_done;
        m_idx++;
        if (m_idx == NB) begin
            m_done++;
            m_rd_bank  = m_wr_bank;
            m_wr_bank  = ~m_wr_bank;
            m_rd_valid = 1'b1;
            m_idx      = 0;
            m_sync     = !pend;
        end else if (pend) begin
            m_drop++;
            m_idx = 0;
        end
        repeat (3) tick();
        chk("frame_done_cnt", 32'(seen_done), 32'(m_done));
        chk("frame_drop_cnt", 32'(seen_drop), 32'(m_drop));
        chk("wr_bank", 32'(wr_bank), 32'(m_wr_bank));
        chk("rd_bank", 32'(rd_bank), 32'(m_rd_bank));
        chk("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
        chk("err_sticky", 32'(err_sticky), 32'(m_err));
    endtask

    initial begin
        bit got;
        int fs;
        bit fsd;
        rst = 1'b1; frame_start = 1'b0; usedw = '0; rdata = '0;
        wr_ack = 1'b0; dreq = 1'b0; wr_done = 1'b0;
        m_wr_bank = 0; m_rd_bank = 0; m_rd_valid = 0; m_sync = 1; m_err = 0;
        m_idx = 0; m_done = 0; m_drop = 0;
        repeat (3) tick();
        chk_all_zero("reset");
        rst = 1'b0;

        // SYNC ignores the FIFO until a frame starts
        sync_hold_check("sync_ignore");
        start_frame();
        burst(0, -1, 0, 0);
        burst(1, -1, 0, 0);
        while (m_idx != 0) burst(0, -1, 0, 0);   // rest of frame 0, last burst at B0+(NB-1)*BL

        sync_hold_check("sync_after_frame");
        start_frame();
        repeat (3) burst(0, -1, 0, 0);
        burst(0, 5, 0, 0);                       // truncated mid-burst, address wrapped to 0
        burst(0, -1, 0, 0);                      // restarts at bank 1 base
        while (m_idx != NB - 1) burst(0, -1, 0, 0);
        burst(0, -1, 1, 0);                      // frame_start coincident with final wr_done
        burst(0, -1, 0, 0);                      // no SYNC wait, bank 0 base

        repeat (12) begin
            if (m_sync) start_frame();
            fs  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, BL - 1)) : -1;
            fsd = (m_idx == NB - 1) && ($urandom_range(0, 1) == 1);
            burst(0, fs, fsd, 0);
        end

        if (m_sync) start_frame();
        burst(0, -1, 0, 1);                      // overrun data_req flags error

        // reset in the middle of a data phase
        if (m_sync) start_frame();
        usedw = 11'(BL);
        wait_req(got);
        wr_ack = 1'b1;
        tick();
        wr_ack = 1'b0;
        repeat (8) begin
            dreq = 1'b1;
            tick();
        end
        dreq = 1'b0; rdata = '0; rst = 1'b1;
        tick();
        chk_all_zero("mid_rst");
        rst = 1'b0;
        m_wr_bank = 0; m_rd_bank = 0; m_rd_valid = 0; m_sync = 1; m_err = 0; m_idx = 0;
        sync_hold_check("sync_after_rst");
        start_frame();
        burst(0, -1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
